// File: rtl/btn_pkg.sv
// Shared types and helpers for the push-button conditioner.
//   btn_state_t : per-channel debounce / hold state
//   cnt_w()     : counter width able to hold values 0..max (never below 1 bit)
package btn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DB_ON  = 2'd1,
        ST_HELD   = 2'd2,
        ST_DB_OFF = 2'd3
    } btn_state_t;

    function automatic int cnt_w(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-FF synchroniser, debounce FSM and auto-repeat timer.
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   btn_n          : raw button, 0 = pressed, asynchronous to clk
//   level          : debounced state, 1 = pressed
//   press_pulse    : 1-cycle pulse when level rises
//   release_pulse  : 1-cycle pulse when level falls
//   step_pulse     : 1-cycle pulse on press and on each auto-repeat tick
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | released and stable
// ST_DB_ON  | pressed level seen, counting stable samples before accept
// ST_HELD   | accepted press, auto-repeat timer running
// ST_DB_OFF | released level seen while held, counting before accept
module btn_channel
    import btn_pkg::*;
#(
    parameter int DB_CYCLES  = 500000,
    parameter int REP_DELAY  = 25000000,
    parameter int REP_PERIOD = 5000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic step_pulse
);

    localparam int DB_W  = cnt_w(DB_CYCLES);
    localparam int REP_W = cnt_w(REP_DELAY);

    // db_cnt counts stable samples seen so far; the sample that would make it
    // DB_CYCLES is the accepting one, so compare against DB_CYCLES-1.
    localparam logic [DB_W-1:0]  DB_ONE  = DB_W'(1);
    localparam logic [DB_W-1:0]  DB_LAST = DB_W'(DB_CYCLES - 1);

    // rep_cnt equals the number of cycles since the last STEP edge; reloading
    // to DELAY-PERIOD+1 makes the next hit land exactly PERIOD cycles later.
    // A period longer than the delay cannot be represented in this width, so
    // it is clamped to the delay.
    localparam logic [REP_W-1:0] REP_ONE    = REP_W'(1);
    localparam logic [REP_W-1:0] REP_TOP    = REP_W'(REP_DELAY);
    localparam logic [REP_W-1:0] REP_RELOAD = (REP_PERIOD >= REP_DELAY) ? REP_ONE
                                              : REP_W'(REP_DELAY - REP_PERIOD + 1);
    localparam bit               REP_EN     = (REP_PERIOD != 0);

    logic             sync1;
    logic             sync2;
    logic             s;
    btn_state_t       state;
    logic [DB_W-1:0]  db_cnt;
    logic [DB_W-1:0]  db_inc;
    logic [REP_W-1:0] rep_cnt;
    logic [REP_W-1:0] rep_next;
    logic             rep_hit;

    assign s = ~sync2;

    always_comb begin
        db_inc   = (db_cnt == '1) ? db_cnt : db_cnt + DB_ONE;
        rep_hit  = REP_EN && (rep_cnt == REP_TOP);
        rep_next = rep_cnt;
        if (rep_hit) begin
            rep_next = REP_RELOAD;
        end else if (rep_cnt != '1) begin
            rep_next = rep_cnt + REP_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1         <= 1'b1;
            sync2         <= 1'b1;
            state         <= ST_IDLE;
            db_cnt        <= '0;
            rep_cnt       <= '0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            step_pulse    <= 1'b0;
        end else begin
            sync1         <= btn_n;
            sync2         <= sync1;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            step_pulse    <= 1'b0;

            case (state)
                ST_IDLE: begin
                    db_cnt  <= '0;
                    rep_cnt <= '0;
                    if (s) begin
                        // A single-sample debounce accepts immediately.
                        if (DB_LAST == '0) begin
                            state       <= ST_HELD;
                            level       <= 1'b1;
                            press_pulse <= 1'b1;
                            step_pulse  <= 1'b1;
                            rep_cnt     <= REP_ONE;
                        end else begin
                            state  <= ST_DB_ON;
                            db_cnt <= DB_ONE;
                        end
                    end
                end

                ST_DB_ON: begin
                    if (!s) begin
                        state  <= ST_IDLE;
                        db_cnt <= '0;
                    end else if (db_cnt == DB_LAST) begin
                        state       <= ST_HELD;
                        db_cnt      <= '0;
                        level       <= 1'b1;
                        press_pulse <= 1'b1;
                        step_pulse  <= 1'b1;
                        rep_cnt     <= REP_ONE;
                    end else begin
                        db_cnt <= db_inc;
                    end
                end

                ST_HELD: begin
                    if (!s && (DB_LAST == '0)) begin
                        state         <= ST_IDLE;
                        level         <= 1'b0;
                        release_pulse <= 1'b1;
                        rep_cnt       <= '0;
                    end else begin
                        if (!s) begin
                            state  <= ST_DB_OFF;
                            db_cnt <= DB_ONE;
                        end
                        rep_cnt    <= rep_next;
                        step_pulse <= rep_hit;
                    end
                end

                ST_DB_OFF: begin
                    if (s) begin
                        // Release glitch: repeat timing carries on untouched.
                        state      <= ST_HELD;
                        db_cnt     <= '0;
                        rep_cnt    <= rep_next;
                        step_pulse <= rep_hit;
                    end else if (db_cnt == DB_LAST) begin
                        // Release wins over any repeat tick due this cycle.
                        state         <= ST_IDLE;
                        db_cnt        <= '0;
                        rep_cnt       <= '0;
                        level         <= 1'b0;
                        release_pulse <= 1'b1;
                    end else begin
                        db_cnt     <= db_inc;
                        rep_cnt    <= rep_next;
                        step_pulse <= rep_hit;
                    end
                end

                default: begin
                    state   <= ST_IDLE;
                    db_cnt  <= '0;
                    rep_cnt <= '0;
                    level   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// Push-button conditioner feeding the BCD counter core: one independent
// synchronise / debounce / auto-repeat channel per button.
// Ports:
//   CLK     : system clock
//   RST     : synchronous active-high reset
//   BTN_N   : raw buttons, 0 = pressed, asynchronous
//   LEVEL   : debounced state per button, 1 = pressed
//   PRESS   : 1-cycle pulse per button when LEVEL rises
//   RELEASE : 1-cycle pulse per button when LEVEL falls
//   STEP    : 1-cycle pulse per button on press and on each auto-repeat tick
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int N_BTN      = 2,
    parameter int DB_CYCLES  = 500000,
    parameter int REP_DELAY  = 25000000,
    parameter int REP_PERIOD = 5000000
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_BTN-1:0] BTN_N,
    output logic [N_BTN-1:0] LEVEL,
    output logic [N_BTN-1:0] PRESS,
    output logic [N_BTN-1:0] RELEASE,
    output logic [N_BTN-1:0] STEP
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        btn_channel #(
            .DB_CYCLES  (DB_CYCLES),
            .REP_DELAY  (REP_DELAY),
            .REP_PERIOD (REP_PERIOD)
        ) u_chan (
            .clk           (CLK),
            .rst           (RST),
            .btn_n         (BTN_N[i]),
            .level         (LEVEL[i]),
            .press_pulse   (PRESS[i]),
            .release_pulse (RELEASE[i]),
            .step_pulse    (STEP[i])
        );
    end

endmodule
